period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter_if.sv | 12 +
 rtl/period_meter.sv | 72 +++++++
 tb/tb_period_meter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/period_meter_if.sv
// period_meter_if: control inputs and measurement results of a period meter.
interface period_meter_if #(parameter int COUNT_SIZE = 8);
  logic enable;
  logic pulseIn;
  logic [COUNT_SIZE-1:0] periodOut;
  logic [7:0] amountOut;
  logic valid;
  logic ovf;
  logic busy;
  modport master (output enable, pulseIn, input periodOut, amountOut, valid, ovf, busy);
  modport slave (input enable, pulseIn, output periodOut, amountOut, valid, ovf, busy);
endinterface

// File: rtl/period_meter.sv
// period_meter: measures rising-edge to rising-edge period of pulseIn in clk cycles.
module period_meter #(parameter int COUNT_SIZE = 8) (
  input logic clk,
  input logic rst,
  period_meter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] ARMED = 2'b01;
  localparam logic [1:0] MEASURE = 2'b10;
  logic [1:0] state;
  logic [COUNT_SIZE-1:0] cnt;
  logic [COUNT_SIZE-1:0] period;
  logic [7:0] amount;
  logic pulse_prev;
  logic valid_q;
  logic ovf_q;
  logic rise;
  assign rise = bus.pulseIn & ~pulse_prev;
  // An edge wins over saturation so a full 2^COUNT_SIZE-1 period is still captured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      period <= '0;
      amount <= '0;
      pulse_prev <= 1'b0;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      pulse_prev <= bus.pulseIn;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
      if (!bus.enable) begin
        state <= IDLE;
        cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= ARMED;
            cnt <= '0;
          end
          ARMED: if (rise) begin
            state <= MEASURE;
            cnt <= COUNT_SIZE'(1);
          end
          MEASURE: if (rise) begin
            period <= cnt;
            amount <= cnt[COUNT_SIZE-1 -: 8];
            cnt <= COUNT_SIZE'(1);
            valid_q <= 1'b1;
          end else if (&cnt) begin
            state <= ARMED;
            cnt <= '0;
            ovf_q <= 1'b1;
          end else begin
            cnt <= cnt + COUNT_SIZE'(1);
          end
          default: begin
            state <= IDLE;
            cnt <= '0;
          end
        endcase
      end
    end
  end
  // MEASURE is the only encoding with bit 1 set, so busy is a plain state bit.
  assign bus.busy = state[1];
  assign bus.periodOut = period;
  assign bus.amountOut = amount;
  assign bus.valid = valid_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed table-driven check of period_meter at COUNT_SIZE 8 and 12.
module tb_period_meter;
  typedef struct {
    int dut;
    int gap;
    logic v;
    logic b;
    int p;
    int gov;
  } row_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic pin = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  int v8 = 0, o8 = 0, v12 = 0, o12 = 0, both = 0;
  row_t tbl[20];
  period_meter_if #(.COUNT_SIZE(8)) if8 ();
  period_meter_if #(.COUNT_SIZE(12)) if12 ();
  assign if8.enable = en;
  assign if8.pulseIn = pin;
  assign if12.enable = en;
  assign if12.pulseIn = pin;
  period_meter #(.COUNT_SIZE(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  period_meter #(.COUNT_SIZE(12)) dut12 (.clk(clk), .rst(rst), .bus(if12));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step(input logic p);
    pin = p;
    @(posedge clk);
    #1;
    v8 += int'(if8.valid);
    o8 += int'(if8.ovf);
    v12 += int'(if12.valid);
    o12 += int'(if12.ovf);
    both += int'((if8.valid & if8.ovf) | (if12.valid & if12.ovf));
  endtask
  task automatic run_row(input int i);
    row_t r;
    r = tbl[i];
    v8 = 0; o8 = 0; v12 = 0; o12 = 0;
    repeat (r.gap - 1) step(1'b0);
    chk($sformatf("row%0d_gap_valid", i), r.dut == 8 ? v8 : v12, 0);
    chk($sformatf("row%0d_gap_ovf", i), r.dut == 8 ? o8 : o12, r.gov);
    step(1'b1);
    if (r.dut == 8) begin
      chk($sformatf("row%0d_valid8", i), 32'(if8.valid), 32'(r.v));
      chk($sformatf("row%0d_busy8", i), 32'(if8.busy), 32'(r.b));
      chk($sformatf("row%0d_period8", i), 32'(if8.periodOut), r.p);
      chk($sformatf("row%0d_amount8", i), 32'(if8.amountOut), 32'(r.p[7:0]));
    end else begin
      chk($sformatf("row%0d_valid12", i), 32'(if12.valid), 32'(r.v));
      chk($sformatf("row%0d_busy12", i), 32'(if12.busy), 32'(r.b));
      chk($sformatf("row%0d_period12", i), 32'(if12.periodOut), r.p);
      chk($sformatf("row%0d_amount12", i), 32'(if12.amountOut), 32'(r.p[11:4]));
    end
  endtask
  initial begin
    int first;
    tbl[0] = '{8, 3, 1'b0, 1'b1, 0, 0};
    tbl[1] = '{8, 10, 1'b1, 1'b1, 10, 0};
    tbl[2] = '{8, 10, 1'b1, 1'b1, 10, 0};
    tbl[3] = '{8, 10, 1'b1, 1'b1, 10, 0};
    tbl[4] = '{8, 2, 1'b1, 1'b1, 2, 0};
    tbl[5] = '{8, 255, 1'b1, 1'b1, 255, 0};
    tbl[6] = '{8, 20, 1'b1, 1'b1, 20, 0};
    tbl[7] = '{12, 'h3A5, 1'b1, 1'b1, 'h3A5, 0};
    tbl[8] = '{12, 'h3A5, 1'b1, 1'b1, 'h3A5, 0};
    tbl[9] = '{12, 2, 1'b1, 1'b1, 2, 0};
    tbl[10] = '{12, 4095, 1'b1, 1'b1, 4095, 0};
    tbl[11] = '{12, 2, 1'b1, 1'b1, 2, 0};
    tbl[12] = '{12, 4095, 1'b1, 1'b1, 4095, 0};
    tbl[13] = '{8, 20, 1'b1, 1'b1, 20, 0};
    tbl[14] = '{8, 4, 1'b0, 1'b1, 20, 0};
    tbl[15] = '{8, 13, 1'b1, 1'b1, 13, 0};
    tbl[16] = '{8, 13, 1'b1, 1'b1, 13, 0};
    tbl[17] = '{8, 3, 1'b0, 1'b1, 0, 0};
    tbl[18] = '{8, 17, 1'b1, 1'b1, 17, 0};
    tbl[19] = '{12, 6, 1'b1, 1'b1, 6, 0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_period8", 32'(if8.periodOut), 0);
    chk("rst_amount8", 32'(if8.amountOut), 0);
    chk("rst_valid8", 32'(if8.valid), 0);
    chk("rst_ovf8", 32'(if8.ovf), 0);
    chk("rst_busy8", 32'(if8.busy), 0);
    chk("rst_period12", 32'(if12.periodOut), 0);
    rst = 1'b1;
    step(1'b0);
    step(1'b1);
    step(1'b0);
    chk("disabled_busy", 32'(if8.busy), 0);
    en = 1'b1;
    step(1'b1);
    chk("idle_edge_busy", 32'(if8.busy), 0);
    for (int i = 0; i <= 6; i++) run_row(i);
    v8 = 0; o8 = 0; first = -1;
    for (int k = 1; k <= 300; k++) begin
      step(1'b0);
      if (if8.ovf && first < 0) first = k;
    end
    chk("sat_ovf_count", o8, 1);
    chk("sat_ovf_delay", first, 255);
    chk("sat_no_valid", v8, 0);
    chk("sat_busy", 32'(if8.busy), 0);
    chk("sat_period_hold", 32'(if8.periodOut), 20);
    chk("sat_amount_hold", 32'(if8.amountOut), 20);
    step(1'b1);
    chk("rearm_valid", 32'(if8.valid), 0);
    chk("rearm_busy", 32'(if8.busy), 1);
    chk("long_period12", 32'(if12.periodOut), 301);
    for (int i = 7; i <= 13; i++) run_row(i);
    v8 = 0; o8 = 0;
    repeat (6) step(1'b0);
    en = 1'b0;
    step(1'b0);
    chk("dis_busy", 32'(if8.busy), 0);
    step(1'b0);
    step(1'b0);
    en = 1'b1;
    step(1'b0);
    chk("dis_valid", v8, 0);
    chk("dis_ovf", o8, 0);
    chk("dis_busy_armed", 32'(if8.busy), 0);
    chk("dis_period_hold", 32'(if8.periodOut), 20);
    chk("dis_amount_hold", 32'(if8.amountOut), 20);
    for (int i = 14; i <= 16; i++) run_row(i);
    repeat (5) step(1'b0);
    #2 rst = 1'b0;
    #1;
    chk("async_period8", 32'(if8.periodOut), 0);
    chk("async_amount8", 32'(if8.amountOut), 0);
    chk("async_busy8", 32'(if8.busy), 0);
    chk("async_period12", 32'(if12.periodOut), 0);
    chk("async_busy12", 32'(if12.busy), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    step(1'b0);
    for (int i = 17; i <= 19; i++) run_row(i);
    chk("valid_ovf_excl", both, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
